otter_wb_regfile: RTL and testbench

OTTER_WB_REGFILE -- requirements
Module: otter_wb_regfile

---
 rtl/otter_wb_regfile.sv | 107 ++++++++++
 tb/tb_otter_wb_regfile.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/otter_wb_regfile.sv
// Writeback-stage register file for the OTTER pipeline.
// Selects the writeback result, stores it into x1..x31, serves two
// combinational decode-stage read ports with write-through bypass, and
// counts retired (valid) instructions.
module otter_wb_regfile #(
    parameter logic [31:0] SP_INIT  = 32'h0000_FFFC,
    parameter int          RETIRE_W = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RegWriteW,
    input  logic [1:0]          ResultSrcW,
    input  logic [31:0]         ALUResultW,
    input  logic [31:0]         ReadDataW,
    input  logic [4:0]          RdW,
    input  logic [31:0]         PCPlus4W,
    input  logic                ValidW,
    input  logic [4:0]          Rs1D,
    input  logic [4:0]          Rs2D,
    output logic [31:0]         RD1D,
    output logic [31:0]         RD2D,
    output logic [31:0]         ResultW,
    output logic [RETIRE_W-1:0] RetireCount
);

    // x0 is hard-wired to zero, so only x1..x31 get storage.
    logic [31:0]         regs_q [1:31];
    logic [RETIRE_W-1:0] retire_q;
    logic [RETIRE_W-1:0] retire_d;

    logic writeEn;
    logic bypassRs1;
    logic bypassRs2;

    // Writeback mux; encoding 11 is unused by the decoder and falls back to the ALU result.
    always_comb begin
        ResultW = ALUResultW;
        case (ResultSrcW)
            2'b00:   ResultW = ALUResultW;
            2'b01:   ResultW = ReadDataW;
            2'b10:   ResultW = PCPlus4W;
            default: ResultW = ALUResultW;
        endcase
    end

    // A write commits only for a real instruction targeting a non-zero register outside reset.
    always_comb begin
        writeEn   = RegWriteW && ValidW && (RdW != 5'd0) && !RST;
        bypassRs1 = writeEn && (RdW == Rs1D);
        bypassRs2 = writeEn && (RdW == Rs2D);
    end

    // Read port 1: zero for x0, in-flight writeback value on a match, else storage.
    always_comb begin
        RD1D = 32'h0;
        if (Rs1D != 5'd0) begin
            if (bypassRs1) begin
                RD1D = ResultW;
            end else begin
                RD1D = regs_q[Rs1D];
            end
        end
    end

    // Read port 2: same behaviour as port 1, resolved independently.
    always_comb begin
        RD2D = 32'h0;
        if (Rs2D != 5'd0) begin
            if (bypassRs2) begin
                RD2D = ResultW;
            end else begin
                RD2D = regs_q[Rs2D];
            end
        end
    end

    // Register storage: reset clears everything except the stack pointer, which gets SP_INIT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= (i == 2) ? SP_INIT : 32'h0;
            end
        end else if (writeEn) begin
            regs_q[RdW] <= ResultW;
        end
    end

    // Retired-instruction counter advances on every valid instruction and wraps silently.
    always_comb begin
        retire_d = retire_q;
        if (ValidW) begin
            retire_d = retire_q + RETIRE_W'(1);
        end
    end

    // Counter register; reset wins over a simultaneous retire.
    always_ff @(posedge CLK) begin
        if (RST) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign RetireCount = retire_q;

endmodule

// File: tb/tb_otter_wb_regfile.sv
// Self-checking bench for otter_wb_regfile: directed scenarios plus
// randomized traffic checked against an architectural register model.
module tb_otter_wb_regfile;

    localparam logic [31:0] SP = 32'h0000_FFFC;

    logic        CLK;
    logic        RST;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [31:0] PCPlus4W;
    logic        ValidW;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ResultW;
    logic [31:0] RetireCount;

    logic [31:0] rd1W4;
    logic [31:0] rd2W4;
    logic [31:0] resultW4;
    logic [3:0]  retireW4;

    int checks;
    int failures;

    // Architectural model: 32 registers (index 0 always zero) and a wide retire count.
    logic [31:0] model [0:31];
    logic [31:0] retireModel;

    otter_wb_regfile dut (
        .CLK(CLK), .RST(RST), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW),
        .PCPlus4W(PCPlus4W), .ValidW(ValidW), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW), .RetireCount(RetireCount)
    );

    otter_wb_regfile #(.RETIRE_W(4)) dutW4 (
        .CLK(CLK), .RST(RST), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW),
        .PCPlus4W(PCPlus4W), .ValidW(ValidW), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RD1D(rd1W4), .RD2D(rd2W4), .ResultW(resultW4), .RetireCount(retireW4)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] expResult();
        if (ResultSrcW == 2'b01) return ReadDataW;
        if (ResultSrcW == 2'b10) return PCPlus4W;
        return ALUResultW;
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (!RST && RegWriteW && ValidW && RdW == idx) return expResult();
        return model[idx];
    endfunction

    // Advance one clock edge and apply the architectural effect of the inputs held across it.
    task automatic cycle();
        @(posedge CLK);
        if (RST) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            model[2] = SP;
            retireModel = 32'h0;
        end else begin
            if (RegWriteW && ValidW && RdW != 5'd0) model[RdW] = expResult();
            if (ValidW) retireModel = retireModel + 32'd1;
        end
        #1;
    endtask

    task automatic idle();
        RST = 1'b0; RegWriteW = 1'b0; ValidW = 1'b0; ResultSrcW = 2'b00;
        ALUResultW = 32'h0; ReadDataW = 32'h0; PCPlus4W = 32'h0; RdW = 5'd0;
    endtask

    task automatic test_reset();
        idle();
        RST = 1'b1;
        cycle();
        idle();
        Rs1D = 5'd2; Rs2D = 5'd5;
        #1;
        checks++;
        if (RD1D !== SP) begin failures++; $display("FAIL reset_x2: got %h expected %h", RD1D, SP); end
        checks++;
        if (RD2D !== 32'h0) begin failures++; $display("FAIL reset_x5: got %h expected %h", RD2D, 32'h0); end
        checks++;
        if (RetireCount !== 32'h0) begin failures++; $display("FAIL reset_retire: got %0d expected 0", RetireCount); end
    endtask

    task automatic test_bypass();
        idle();
        RegWriteW = 1'b1; ValidW = 1'b1; RdW = 5'd7; ResultSrcW = 2'b01;
        ReadDataW = 32'hDEAD_BEEF; Rs1D = 5'd7; Rs2D = 5'd7;
        #1;
        checks++;
        if (RD1D !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_rd1: got %h expected %h", RD1D, 32'hDEAD_BEEF); end
        checks++;
        if (RD2D !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_rd2_same: got %h expected %h", RD2D, 32'hDEAD_BEEF); end
        cycle();
        idle();
        #1;
        checks++;
        if (RD1D !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stored_x7: got %h expected %h", RD1D, 32'hDEAD_BEEF); end
    endtask

    task automatic test_x0();
        idle();
        RegWriteW = 1'b1; ValidW = 1'b1; RdW = 5'd0; ALUResultW = 32'h1234;
        Rs1D = 5'd0; Rs2D = 5'd0;
        #1;
        checks++;
        if (RD1D !== 32'h0) begin failures++; $display("FAIL x0_write_rd1: got %h expected 0", RD1D); end
        checks++;
        if (RD2D !== 32'h0) begin failures++; $display("FAIL x0_write_rd2: got %h expected 0", RD2D); end
        cycle();
        idle();
        #1;
        checks++;
        if (RD1D !== 32'h0) begin failures++; $display("FAIL x0_after_rd1: got %h expected 0", RD1D); end
        checks++;
        if (RD2D !== 32'h0) begin failures++; $display("FAIL x0_after_rd2: got %h expected 0", RD2D); end
    endtask

    task automatic test_result_sel();
        logic [31:0] want [0:3];
        want[0] = 32'd1; want[1] = 32'd2; want[2] = 32'd3; want[3] = 32'd1;
        idle();
        ALUResultW = 32'd1; ReadDataW = 32'd2; PCPlus4W = 32'd3;
        for (int s = 0; s < 4; s++) begin
            ResultSrcW = 2'(s);
            #1;
            checks++;
            if (ResultW !== want[s]) begin
                failures++;
                $display("FAIL result_sel_%0d: got %h expected %h", s, ResultW, want[s]);
            end
        end
    endtask

    task automatic test_reset_priority();
        idle();
        cycle();
        RST = 1'b1; RegWriteW = 1'b1; ValidW = 1'b1; RdW = 5'd9;
        ALUResultW = 32'h55; Rs1D = 5'd9;
        #1;
        checks++;
        if (RD1D !== model[9]) begin failures++; $display("FAIL reset_no_bypass: got %h expected %h", RD1D, model[9]); end
        cycle();
        idle();
        #1;
        checks++;
        if (RD1D !== 32'h0) begin failures++; $display("FAIL reset_prio_x9: got %h expected 0", RD1D); end
        checks++;
        if (RetireCount !== 32'h0) begin failures++; $display("FAIL reset_prio_retire: got %0d expected 0", RetireCount); end
    endtask

    task automatic test_random();
        logic [31:0] e1;
        logic [31:0] e2;
        for (int n = 0; n < 300; n++) begin
            RST        = ($urandom_range(0, 24) == 0);
            RegWriteW  = ($urandom_range(0, 3) != 0);
            ValidW     = ($urandom_range(0, 4) != 0);
            ResultSrcW = 2'($urandom_range(0, 3));
            ALUResultW = $urandom;
            ReadDataW  = $urandom;
            PCPlus4W   = $urandom;
            RdW        = 5'($urandom_range(0, 31));
            Rs1D       = ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom_range(0, 31));
            Rs2D       = ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom_range(0, 31));
            #1;
            e1 = expRead(Rs1D);
            e2 = expRead(Rs2D);
            checks++;
            if (RD1D !== e1) begin failures++; $display("FAIL rand_rd1 it=%0d rs1=%0d: got %h expected %h", n, Rs1D, RD1D, e1); end
            checks++;
            if (RD2D !== e2) begin failures++; $display("FAIL rand_rd2 it=%0d rs2=%0d: got %h expected %h", n, Rs2D, RD2D, e2); end
            checks++;
            if (ResultW !== expResult()) begin failures++; $display("FAIL rand_result it=%0d: got %h expected %h", n, ResultW, expResult()); end
            checks++;
            if (RetireCount !== retireModel) begin failures++; $display("FAIL rand_retire it=%0d: got %0d expected %0d", n, RetireCount, retireModel); end
            checks++;
            if (retireW4 !== retireModel[3:0]) begin failures++; $display("FAIL rand_retire_w4 it=%0d: got %0d expected %0d", n, retireW4, retireModel[3:0]); end
            cycle();
        end
    endtask

    task automatic test_retire_wrap();
        idle();
        RST = 1'b1;
        cycle();
        idle();
        ValidW = 1'b1;
        for (int k = 0; k < 15; k++) cycle();
        checks++;
        if (retireW4 !== 4'hF) begin failures++; $display("FAIL retire_w4_full: got %0d expected 15", retireW4); end
        cycle();
        checks++;
        if (retireW4 !== 4'h0) begin failures++; $display("FAIL retire_w4_wrap: got %0d expected 0", retireW4); end
        checks++;
        if (RetireCount !== 32'd16) begin failures++; $display("FAIL retire_wide_16: got %0d expected 16", RetireCount); end
        ValidW = 1'b0;
        cycle();
        checks++;
        if (retireW4 !== 4'h0) begin failures++; $display("FAIL retire_w4_hold: got %0d expected 0", retireW4); end
        checks++;
        if (RetireCount !== retireModel) begin failures++; $display("FAIL retire_wide_hold: got %0d expected %0d", RetireCount, retireModel); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        retireModel = 32'h0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        Rs1D = 5'd0; Rs2D = 5'd0;
        idle();
        test_reset();
        test_bypass();
        test_x0();
        test_result_sel();
        test_reset_priority();
        test_random();
        test_retire_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
